icache: RTL and testbench

- Direct-mapped instruction cache between the IF stage and the memory controller's instruction-fetch port.
- Acts as initiator on that port: it issues instr_out_enable and instr_out_addr, then consumes instr_out_valid and instr_out.
- Serves 32-bit instructions to fetch. Hits are combinational; misses refill one word per line.

---
 rtl/icache_pkg.sv | 12 +
 rtl/icache_array.sv | 46 ++++
 rtl/icache.sv | 110 +++++++++++
 tb/tb_icache.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state encoding and default geometry.
// Define ICACHE_BYPASS_EN at build time to forward the refill word straight to fetch during a miss.
package icache_pkg;

  localparam int ICACHE_INDEX_BITS = 6;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the icache: one combinational read port, one synchronous write port.
// Only the valid bits are cleared by reset; tag and data contents are left as they are.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hit path, single-word refill through the instruction-fetch port.
// Optional ICACHE_BYPASS_EN forwards instr_out to fetch on the refill cycle when the miss address is still requested.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        instr_out_enable,
  output logic [31:0] instr_out_addr,
  input  logic        instr_out_valid,
  input  logic [31:0] instr_out
);

  ic_state_e             state, state_next;
  logic [31:0]           miss_addr, miss_addr_next;
  logic [31:0]           fetch_addr_next;
  logic                  fetch_en_next;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [31:0]           line_data;
  logic                  hit;
  logic                  refill;
  logic                  bypass_hit;
  logic                  unused_addr_bits;

  assign idx     = if_addr[2+INDEX_BITS-1:2];
  assign req_tag = if_addr[31:2+INDEX_BITS];

  assign hit    = if_req & line_valid & (line_tag == req_tag) & (state == IC_IDLE) & rdy;
  assign refill = rdy & (state == IC_MISS) & instr_out_valid;

`ifdef ICACHE_BYPASS_EN
  assign bypass_hit = refill & if_req & (if_addr[31:2] == miss_addr[31:2]);
`else
  assign bypass_hit = 1'b0;
`endif

  assign if_valid = hit | bypass_hit;
  assign if_instr = bypass_hit ? instr_out : line_data;

  assign unused_addr_bits = ^{if_addr[1:0], miss_addr[1:0]};

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (refill & rst),
    .wr_idx   (miss_addr[2+INDEX_BITS-1:2]),
    .wr_tag   (miss_addr[31:2+INDEX_BITS]),
    .wr_data  (instr_out)
  );

  // A started fetch always runs to its valid pulse; rdy low freezes everything.
  always_comb begin
    state_next      = state;
    miss_addr_next  = miss_addr;
    fetch_en_next   = instr_out_enable;
    fetch_addr_next = instr_out_addr;
    if (rdy) begin
      case (state)
        IC_IDLE: begin
          if (if_req && !hit) begin
            miss_addr_next  = {if_addr[31:2], 2'b00};
            fetch_addr_next = {if_addr[31:2], 2'b00};
            fetch_en_next   = 1'b1;
            state_next      = IC_MISS;
          end
        end
        IC_MISS: begin
          if (instr_out_valid) begin
            fetch_en_next = 1'b0;
            state_next    = IC_IDLE;
          end
        end
        default: state_next = IC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IC_IDLE;
      miss_addr        <= '0;
      instr_out_enable <= 1'b0;
      instr_out_addr   <= '0;
    end else begin
      state            <= state_next;
      miss_addr        <= miss_addr_next;
      instr_out_enable <= fetch_en_next;
      instr_out_addr   <= fetch_addr_next;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a fixed-latency fetch responder, a line-address reference model,
// table-driven accesses, hand-written multi-cycle sequences and randomized requests.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        instr_out_enable;
  logic [31:0] instr_out_addr;
  logic        instr_out_valid;
  logic [31:0] instr_out;

  int vectors     = 0;
  int miscompares = 0;
  int fetch_count = 0;

  bit          model_valid [64];
  logic [29:0] model_word  [64];

`ifdef ICACHE_BYPASS_EN
  localparam int  MISS_LAT = 7;
  localparam bit  BYPASS   = 1'b1;
`else
  localparam int  MISS_LAT = 8;
  localparam bit  BYPASS   = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  icache dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .instr_out_enable (instr_out_enable),
    .instr_out_addr   (instr_out_addr),
    .instr_out_valid  (instr_out_valid),
    .instr_out        (instr_out)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h0100_0193) ^ 32'h0000_0093;
  endfunction

  function automatic int lineOf(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
  endtask

  task automatic modelFill(input logic [31:0] a);
    model_valid[lineOf(a)] = 1'b1;
    model_word[lineOf(a)]  = a[31:2];
  endtask

  function automatic bit modelHit(input logic [31:0] a);
    return model_valid[lineOf(a)] && (model_word[lineOf(a)] == a[31:2]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Responder: accepts in its first idle cycle, pulses valid six cycles later, holds it until a rdy edge.
  initial begin
    logic [31:0] fa;
    instr_out_valid = 1'b0;
    instr_out       = 32'h0;
    forever begin
      if (instr_out_enable === 1'b1) begin
        fetch_count++;
        fa = instr_out_addr;
        repeat (6) @(posedge clk);
        #1;
        instr_out_valid = 1'b1;
        instr_out       = memWord(fa);
        do @(posedge clk); while (rdy !== 1'b1);
        #1;
        instr_out_valid = 1'b0;
        instr_out       = 32'hDEAD_BEEF;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  end

  // One fetch; on a miss, measures latency, checks the single refill and updates the model.
  task automatic applyStimulus(input logic [31:0] addr, input bit exp_hit, input string nm);
    int start;
    int cyc;
    bit got;
    start   = fetch_count;
    if_req  = 1'b1;
    if_addr = addr;
    #1;
    checkOutput($sformatf("%s if_valid", nm), if_valid, exp_hit);
    if (exp_hit) begin
      checkOutput($sformatf("%s if_instr", nm), if_instr, memWord(addr));
    end else begin
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
        @(posedge clk);
        #2;
        cyc++;
        if (cyc == 1) begin
          checkOutput($sformatf("%s enable", nm), instr_out_enable, 1'b1);
          checkOutput($sformatf("%s fetch addr", nm), instr_out_addr, {addr[31:2], 2'b00});
        end
        if (if_valid === 1'b1) got = 1'b1;
      end
      checkOutput($sformatf("%s latency", nm), cyc, MISS_LAT);
      checkOutput($sformatf("%s refill instr", nm), if_instr, memWord(addr));
      nextCycle();
      #1;
      checkOutput($sformatf("%s enable dropped", nm), instr_out_enable, 1'b0);
      checkOutput($sformatf("%s hit after fill", nm), if_valid, 1'b1);
      nextCycle();
      #1;
      checkOutput($sformatf("%s fetch count", nm), fetch_count - start, 1);
      modelFill(addr);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int start;
    int first;
    logic [31:0] a;

    vecs[0] = '{32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0004, 1'b0};
    vecs[3] = '{32'h0000_0104, 1'b0};
    vecs[4] = '{32'h0000_0004, 1'b0};
    vecs[5] = '{32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_0104, 1'b0};
    vecs[7] = '{32'h0000_0003, 1'b1};
    vecs[8] = '{32'h0000_0106, 1'b1};

    rst     = 1'b0;
    rdy     = 1'b1;
    if_req  = 1'b0;
    if_addr = 32'h0;
    modelClear();
    repeat (3) nextCycle();
    #1;
    checkOutput("reset enable", instr_out_enable, 1'b0);
    checkOutput("reset fetch addr", instr_out_addr, 32'h0);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    #1;
    checkOutput("idle if_valid", if_valid, 1'b0);

    for (int i = 0; i < 9; i++) begin
      nextCycle();
      applyStimulus(vecs[i].addr, vecs[i].exp_hit, $sformatf("vec%0d", i));
    end

    // Redirect: fill of 0x10 completes, then 0x20 misses in turn.
    nextCycle();
    start   = fetch_count;
    if_req  = 1'b1;
    if_addr = 32'h10;
    first   = 0;
    #1;
    checkOutput("redir c0 if_valid", if_valid, 1'b0);
    for (int c = 1; c <= 40 && first == 0; c++) begin
      nextCycle();
      if (c == 3) if_addr = 32'h20;
      #1;
      if (c == 1) checkOutput("redir first fetch addr", instr_out_addr, 32'h10);
      if (c == 9) checkOutput("redir second fetch addr", instr_out_addr, 32'h20);
      if (if_valid === 1'b1) first = c;
    end
    checkOutput("redir if_valid cycle", first, MISS_LAT + 8);
    checkOutput("redir instr", if_instr, memWord(32'h20));
    nextCycle();
    nextCycle();
    checkOutput("redir fetch count", fetch_count - start, 2);
    modelFill(32'h10);
    modelFill(32'h20);
    nextCycle();
    applyStimulus(32'h10, 1'b1, "redir 0x10 filled");

    // rdy held low for cycles 7..9 while the responder holds its valid pulse.
    nextCycle();
    start   = fetch_count;
    if_req  = 1'b1;
    if_addr = 32'h30;
    repeat (7) nextCycle();
    rdy = 1'b0;
    for (int c = 7; c <= 9; c++) begin
      if (c != 7) nextCycle();
      #1;
      checkOutput($sformatf("stall c%0d if_valid", c), if_valid, 1'b0);
      checkOutput($sformatf("stall c%0d enable", c), instr_out_enable, 1'b1);
    end
    nextCycle();
    rdy = 1'b1;
    #1;
    checkOutput("stall release if_valid", if_valid, BYPASS);
    checkOutput("stall release enable", instr_out_enable, 1'b1);
    nextCycle();
    #1;
    checkOutput("stall done if_valid", if_valid, 1'b1);
    checkOutput("stall done instr", if_instr, memWord(32'h30));
    checkOutput("stall done enable", instr_out_enable, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("stall fetch count", fetch_count - start, 1);
    modelFill(32'h30);

    // rdy low in idle: no hit reported, no miss started.
    nextCycle();
    rdy     = 1'b0;
    if_addr = 32'h0;
    #1;
    checkOutput("rdy low hit suppressed", if_valid, 1'b0);
    if_addr = 32'h40;
    nextCycle();
    #1;
    checkOutput("rdy low no fetch", instr_out_enable, 1'b0);
    rdy    = 1'b1;
    if_req = 1'b0;

    // Reset during a miss; the late valid pulse must not fill the line.
    nextCycle();
    if_req  = 1'b1;
    if_addr = 32'h8;
    nextCycle();
    #1;
    checkOutput("rstmiss enable", instr_out_enable, 1'b1);
    nextCycle();
    nextCycle();
    rst    = 1'b0;
    if_req = 1'b0;
    nextCycle();
    rst = 1'b1;
    #1;
    checkOutput("rstmiss enable cleared", instr_out_enable, 1'b0);
    checkOutput("rstmiss fetch addr", instr_out_addr, 32'h0);
    modelClear();
    repeat (8) nextCycle();
    applyStimulus(32'h0, 1'b0, "post-reset 0x0");
    nextCycle();
    applyStimulus(32'h8, 1'b0, "post-reset 0x8");

    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      nextCycle();
      applyStimulus(a, modelHit(a), $sformatf("rand%0d @%h", i, a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
